// File: rtl/ahb_slave_pkg.sv
// Shared AHB codes, data-phase state encoding and the slave address decode helper.
package ahb_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Data-phase state
    // state | meaning
    // IDLE  | no data phase in progress, OKAY with Hreadyout high
    // XFER  | zero-wait read or write data phase
    // ERR1  | first ERROR cycle, Hreadyout low
    // ERR2  | second ERROR cycle, Hreadyout high, next address phase sampled
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        ERR1 = 2'b10,
        ERR2 = 2'b11
    } dphase_t;

    // True when addr falls outside the window or is not word aligned.
    // The window base is aligned to its power-of-two size, so a mask compare suffices.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] size);
        return ((addr & ~(size - 32'd1)) != base) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB bus signals between the master/driver and the memory slave.
interface ahb_mem_slave_if;

    logic        Hsel;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic        Hreadyin;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    modport master (
        output Hsel, Htrans, Hwrite, Hreadyin, Haddr, Hwdata,
        input  Hreadyout, Hresp, Hrdata
    );

    modport slave (
        input  Hsel, Htrans, Hwrite, Hreadyin, Haddr, Hwdata,
        output Hreadyout, Hresp, Hrdata
    );

endinterface

// File: rtl/ahb_slave_mem.sv
// Word memory backing the slave: async clear, one write port, one combinational read port.
module ahb_slave_mem #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Clear the whole array on reset, otherwise commit the data-phase write.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory slave: address decode, address-phase pipeline registers and response FSM.
module ahb_mem_slave
    import ahb_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic           clock,
    input  logic           Hresetn,
    ahb_mem_slave_if.slave bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] WIN_SIZE = 32'(DEPTH * 4);

    dphase_t       state;
    dphase_t       state_nxt;
    logic [AW-1:0] idx_q;
    logic          write_q;
    logic          accept;
    logic          addr_err;
    logic          wr_en;
    logic [31:0]   rd_data;
    logic          unused_bits;

    // Only Htrans[1] distinguishes an active transfer from IDLE/BUSY.
    assign unused_bits = bus.Htrans[0];

    // During the first error cycle Hreadyout is low, so no address phase can complete.
    assign accept   = bus.Hsel && bus.Hreadyin && bus.Htrans[1] && (state != ERR1);
    assign addr_err = addr_error(bus.Haddr, BASE_ADDR, WIN_SIZE);

    // Data-phase state register; ERR1 doubles as the registered error flag.
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture word index and direction of an accepted address phase.
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            idx_q   <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= bus.Haddr[AW+1:2];
            write_q <= bus.Hwrite;
        end
    end

    // Next data-phase state and bus response for the current data phase.
    always_comb begin
        state_nxt     = IDLE;
        bus.Hreadyout = 1'b1;
        bus.Hresp     = HRESP_OKAY;
        bus.Hrdata    = '0;
        wr_en         = 1'b0;

        case (state)
            XFER: begin
                wr_en = write_q;
                if (!write_q) begin
                    bus.Hrdata = rd_data;
                end
            end
            ERR1: begin
                bus.Hreadyout = 1'b0;
                bus.Hresp     = HRESP_ERROR;
            end
            ERR2: begin
                bus.Hresp = HRESP_ERROR;
            end
            default: begin
            end
        endcase

        if (state == ERR1) begin
            state_nxt = ERR2;
        end else if (accept) begin
            state_nxt = addr_err ? ERR1 : XFER;
        end
    end

    // Write data arrives in the data phase, so it pairs with the registered index.
    ahb_slave_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .rst_n   (Hresetn),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (bus.Hwdata),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave with hand-computed expected responses.
module tb_ahb_mem_slave;
    import ahb_slave_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clock;
    logic Hresetn;
    int   n_checks;
    int   n_errors;

    ahb_mem_slave_if bus();

    ahb_mem_slave #(
        .BASE_ADDR (BASE),
        .DEPTH     (256)
    ) dut (
        .clock   (clock),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic addr_phase(input logic sel, input logic rdyin, input logic [1:0] trans,
                              input logic wr, input logic [31:0] addr);
        bus.Hsel     = sel;
        bus.Hreadyin = rdyin;
        bus.Htrans   = trans;
        bus.Hwrite   = wr;
        bus.Haddr    = addr;
    endtask

    task automatic idle();
        addr_phase(1'b0, 1'b1, HTRANS_IDLE, 1'b0, 32'h0);
    endtask

    task automatic chk_resp(input string tag, input logic rdy, input logic [1:0] resp,
                            input logic [31:0] rdata);
        chk({tag, "_rdy"},  32'(bus.Hreadyout), 32'(rdy));
        chk({tag, "_resp"}, 32'(bus.Hresp), 32'(resp));
        chk({tag, "_rdata"}, bus.Hrdata, rdata);
    endtask

    // Single NONSEQ read followed by an idle cycle; checks the data phase.
    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, addr);
        step();
        idle();
        chk_resp(tag, 1'b1, HRESP_OKAY, exp);
        step();
    endtask

    // Single NONSEQ write, data driven in the data phase.
    task automatic write_one(input logic [31:0] addr, input logic [31:0] data);
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, addr);
        step();
        idle();
        bus.Hwdata = data;
        chk_resp("wr", 1'b1, HRESP_OKAY, 32'h0);
        step();
    endtask

    typedef struct {
        logic       sel;
        logic       rdyin;
        logic [1:0] trans;
    } gate_t;

    gate_t gates [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        Hresetn  = 1'b0;
        bus.Hwdata = 32'h0;
        idle();

        // Reset held for three cycles
        repeat (3) step();
        chk_resp("reset", 1'b1, HRESP_OKAY, 32'h0);
        Hresetn = 1'b1;
        step();
        read_chk("rd_after_reset", BASE, 32'h0);

        // Single write then back-to-back read of the same word
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, BASE + 32'h10);
        step();
        bus.Hwdata = 32'hDEAD_BEEF;
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, BASE + 32'h10);
        chk_resp("single_wr", 1'b1, HRESP_OKAY, 32'h0);
        step();
        idle();
        bus.Hwdata = 32'h0;
        chk_resp("raw_rd", 1'b1, HRESP_OKAY, 32'hDEAD_BEEF);
        step();
        chk_resp("after_rd", 1'b1, HRESP_OKAY, 32'h0);

        // Pipelined burst of four writes then four reads
        for (int i = 0; i < 4; i++) begin
            addr_phase(1'b1, 1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, BASE + 32'(4 * i));
            bus.Hwdata = 32'(i);
            step();
            chk_resp("burst_wr", 1'b1, HRESP_OKAY, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            addr_phase(1'b1, 1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, BASE + 32'(4 * i));
            bus.Hwdata = (i == 0) ? 32'd4 : 32'h0;
            step();
            chk_resp("burst_rd", 1'b1, HRESP_OKAY, 32'(i + 1));
        end
        idle();
        step();
        chk_resp("burst_end", 1'b1, HRESP_OKAY, 32'h0);

        // Out-of-range write: two-cycle ERROR, index 0 must keep its value
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h9000_0000);
        step();
        addr_phase(1'b0, 1'b0, HTRANS_IDLE, 1'b0, 32'h0);
        bus.Hwdata = 32'h0BAD_0BAD;
        chk_resp("oor_c1", 1'b0, HRESP_ERROR, 32'h0);
        step();
        chk_resp("oor_c2", 1'b1, HRESP_ERROR, 32'h0);
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, BASE);
        step();
        idle();
        chk_resp("oor_mem", 1'b1, HRESP_OKAY, 32'd1);
        step();

        // Top word of the window is valid, one past it is an error
        write_one(BASE + 32'h3FC, 32'hA5A5_0001);
        read_chk("top_word", BASE + 32'h3FC, 32'hA5A5_0001);
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, BASE + 32'h400);
        step();
        addr_phase(1'b0, 1'b0, HTRANS_IDLE, 1'b0, 32'h0);
        chk_resp("past_top_c1", 1'b0, HRESP_ERROR, 32'h0);
        step();
        idle();
        chk_resp("past_top_c2", 1'b1, HRESP_ERROR, 32'h0);
        step();

        // Misaligned read
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, BASE + 32'h2);
        step();
        addr_phase(1'b0, 1'b0, HTRANS_IDLE, 1'b0, 32'h0);
        chk_resp("mis_c1", 1'b0, HRESP_ERROR, 32'h0);
        step();
        idle();
        chk_resp("mis_c2", 1'b1, HRESP_ERROR, 32'h0);
        step();
        chk_resp("mis_done", 1'b1, HRESP_OKAY, 32'h0);

        // Gated write attempts must not touch memory
        write_one(BASE + 32'h20, 32'h1234_5678);
        gates[0] = '{sel: 1'b0, rdyin: 1'b1, trans: HTRANS_NONSEQ};
        gates[1] = '{sel: 1'b1, rdyin: 1'b0, trans: HTRANS_NONSEQ};
        gates[2] = '{sel: 1'b1, rdyin: 1'b1, trans: HTRANS_IDLE};
        gates[3] = '{sel: 1'b1, rdyin: 1'b1, trans: HTRANS_BUSY};
        for (int g = 0; g < 4; g++) begin
            addr_phase(gates[g].sel, gates[g].rdyin, gates[g].trans, 1'b1, BASE + 32'h20);
            step();
            idle();
            bus.Hwdata = 32'hFFFF_FFFF;
            chk_resp("gate", 1'b1, HRESP_OKAY, 32'h0);
            step();
        end
        read_chk("gate_mem", BASE + 32'h20, 32'h1234_5678);

        // Reset in the middle of an error response clears outputs and memory
        addr_phase(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, BASE + 32'h41);
        step();
        idle();
        chk_resp("pre_rst", 1'b0, HRESP_ERROR, 32'h0);
        Hresetn = 1'b0;
        #1;
        chk_resp("mid_rst", 1'b1, HRESP_OKAY, 32'h0);
        step();
        Hresetn = 1'b1;
        step();
        read_chk("clr_10", BASE + 32'h10, 32'h0);
        read_chk("clr_20", BASE + 32'h20, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- AHB slave endpoint connected to the DUV side of the team's AHB interface.
- Decodes AHB transfers addressed to it and backs them with an internal 32-bit word memory.
- Returns OKAY or a two-cycle ERROR response and drives read data.
- Sits behind the AHB master/driver as the single addressable slave on the bus.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte base address of the slave window (aligned to window size).
- DEPTH, 256, number of 32-bit words; window size = DEPTH*4 bytes; power of two.

Ports:
- clock  input  1  bus clock; all state updates on rising edge.
- Hresetn  input  1  asynchronous active-low reset.
- Hsel  input  1  slave select.
- Htrans  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hwrite  input  1  1 = write, 0 = read.
- Hreadyin  input  1  bus ready; address phase valid only when high.
- Haddr  input  32  byte address.
- Hwdata  input  32  write data, valid in the data phase.
- Hreadyout  output  1  slave ready.
- Hresp  output  2  00 OKAY, 01 ERROR; 10/11 never driven.
- Hrdata  output  32  read data.

Behaviour:
- Reset (Hresetn low, asynchronous):
  - Hreadyout=1, Hresp=00, Hrdata=0.
  - Pipeline registers cleared; memory cleared to 0.
- Address phase accepted on a rising edge when Hsel=1, Hreadyin=1 and Htrans[1]=1 (NONSEQ/SEQ).
- On acceptance, the following are registered: address, Hwrite, and an error flag.
- Error flag is set when either:
  - Haddr is outside [BASE_ADDR, BASE_ADDR+DEPTH*4-1], or
  - Haddr[1:0]!=0.
- IDLE, BUSY or Hsel=0 with Hreadyin=1: no transfer. Next cycle Hreadyout=1, Hresp=OKAY.
- Valid write, zero wait:
  - In the data-phase cycle Hreadyout=1, Hresp=OKAY.
  - mem[word index] <= Hwdata at the end of that cycle.
  - Word index = (addr-BASE_ADDR)>>2.
- Valid read, zero wait:
  - In the data-phase cycle Hreadyout=1, Hresp=OKAY.
  - Hrdata = mem[word index], driven combinationally from the registered address.
- Hrdata=0 in every cycle that is not a valid read data phase.
- Error transfer, two cycles:
  - Cycle 1: Hreadyout=0, Hresp=01.
  - Cycle 2: Hreadyout=1, Hresp=01.
  - Write data is discarded; Hrdata=0.
  - A new address phase is evaluated only in cycle 2, when Hreadyin=1.
- Back-to-back transfers: a new address phase is accepted in the same cycle as the previous data phase (pipelined).
- Read-after-write to the same address in consecutive transfers returns the newly written data; the write commits before the read data phase.
- Hreadyin=0 with Hsel=1: the address phase is ignored.
- Reset asserted mid-transfer: the transfer is abandoned immediately and outputs take reset values.
- Memory contents already written before the reset are cleared.
- Only full-word transfers are supported; no Hsize input.
- No wait states other than the error first cycle.

Decomposition:
- Package ahb_slave_pkg:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP codes (OKAY, ERROR).
  - Data-phase state enum: IDLE, XFER, ERR1, ERR2.
- Sub-module ahb_slave_mem: DEPTH x 32 array with async clear, one write port and one combinational read port.
- The top level holds the decode logic, pipeline registers and response FSM.

Test Plan:
- Reset: hold Hresetn=0 for 3 cycles -> Hreadyout=1, Hresp=00, Hrdata=0; a subsequent read of 0x8000_0000 returns 0.
- Single write/read: NONSEQ write 0x8000_0010 with Hwdata=0xDEAD_BEEF, then NONSEQ read 0x8000_0010 -> Hrdata=0xDEAD_BEEF, Hresp=00, Hreadyout=1, no wait states.
- Pipelined burst: SEQ writes 0x8000_0000..0x8000_000C with data 1,2,3,4 back-to-back, then 4 pipelined reads -> 1,2,3,4 on consecutive cycles.
- Out-of-range: write 0x9000_0000 -> cycle 1 Hreadyout=0/Hresp=01, cycle 2 Hreadyout=1/Hresp=01; memory unchanged.
- Misaligned: read 0x8000_0002 -> same two-cycle ERROR; Hrdata=0.
- Gating: Hsel=0, or Hreadyin=0, or Htrans=IDLE/BUSY with a write to 0x8000_0020 -> OKAY, and a later read of 0x8000_0020 returns the prior contents.
